// File: rtl/reg_file_cfg_if.sv
// Register-file access bus: strobes, address and data in, registered
// read data and status pulses out.
// Optional macro: REGFILE_PARITY_EN adds Par_Inject (in) and Par_Err (out).
// Ports (master drives): WrEn, RdEn, Address, WrData [, Par_Inject]
// Ports (slave drives):  RdData, RdData_Valid, Addr_Err [, Par_Err]
interface reg_file_cfg_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [WIDTH-1:0]      WrData;
    logic [WIDTH-1:0]      RdData;
    logic                  RdData_Valid;
    logic                  Addr_Err;
`ifdef REGFILE_PARITY_EN
    logic                  Par_Inject;
    logic                  Par_Err;

    modport master (
        output WrEn, RdEn, Address, WrData, Par_Inject,
        input  RdData, RdData_Valid, Addr_Err, Par_Err
    );
    modport slave (
        input  WrEn, RdEn, Address, WrData, Par_Inject,
        output RdData, RdData_Valid, Addr_Err, Par_Err
    );
`else
    modport master (
        output WrEn, RdEn, Address, WrData,
        input  RdData, RdData_Valid, Addr_Err
    );
    modport slave (
        input  WrEn, RdEn, Address, WrData,
        output RdData, RdData_Valid, Addr_Err
    );
`endif
endinterface

// File: rtl/reg_file_cfg.sv
// Parametrised configuration register file. Entries 0..3 are exposed
// continuously as REG0..REG3 for the ALU, UART and clock divider.
// Optional macro: REGFILE_PARITY_EN (per-entry even parity, Par_Err/Par_Inject).
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   bus          reg_file_cfg_if.slave (strobes, address, data, status pulses)
//   REG0..REG3   contents of entries 0..3, straight from storage
module reg_file_cfg #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned REG2_RST   = 32'h81,
    parameter int unsigned REG3_RST   = 32'd32
) (
    input  logic              CLK,
    input  logic              RST,
    reg_file_cfg_if.slave     bus,
    output logic [WIDTH-1:0]  REG0,
    output logic [WIDTH-1:0]  REG1,
    output logic [WIDTH-1:0]  REG2,
    output logic [WIDTH-1:0]  REG3
);
    localparam logic [WIDTH-1:0] REG2_INIT = WIDTH'(REG2_RST);
    localparam logic [WIDTH-1:0] REG3_INIT = WIDTH'(REG3_RST);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             addr_ok_c;
    logic             wr_ok_c;
    logic             rd_ok_c;
    logic             err_c;
    logic [WIDTH-1:0] rd_word_c;

    function automatic logic [WIDTH-1:0] rst_val(input int unsigned idx);
        if (idx == 32'd2)      return REG2_INIT;
        else if (idx == 32'd3) return REG3_INIT;
        else                   return '0;
    endfunction

    // Access decode: conflicting strobes or an address past the last entry is an error.
    always_comb begin
        addr_ok_c = 32'(bus.Address) < DEPTH;
        wr_ok_c   = bus.WrEn & ~bus.RdEn & addr_ok_c;
        rd_ok_c   = bus.RdEn & ~bus.WrEn & addr_ok_c;
        err_c     = (bus.WrEn & bus.RdEn) | ((bus.WrEn | bus.RdEn) & ~addr_ok_c);
    end

    // Read mux; explicit compare keeps non-power-of-two depths from aliasing.
    always_comb begin
        rd_word_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.Address == ADDR_WIDTH'(i)) rd_word_c = mem[i];
        end
    end

    // Storage.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= rst_val(i);
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_ok_c && bus.Address == ADDR_WIDTH'(i)) mem[i] <= bus.WrData;
            end
        end
    end

    // Registered read data and status pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.RdData       <= '0;
            bus.RdData_Valid <= 1'b0;
            bus.Addr_Err     <= 1'b0;
        end else begin
            bus.RdData_Valid <= rd_ok_c;
            bus.Addr_Err     <= err_c;
            if (rd_ok_c) bus.RdData <= rd_word_c;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             rd_par_c;

    always_comb begin
        rd_par_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.Address == ADDR_WIDTH'(i)) rd_par_c = par_q[i];
        end
    end

    // Even-parity bit per entry; Par_Inject flips it to exercise the checker.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) par_q[i] <= ^rst_val(i);
            bus.Par_Err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_ok_c && bus.Address == ADDR_WIDTH'(i))
                    par_q[i] <= (^bus.WrData) ^ bus.Par_Inject;
            end
            bus.Par_Err <= rd_ok_c & ((^rd_word_c) != rd_par_c);
        end
    end
`endif

    assign REG0 = mem[0];
    assign REG1 = mem[1];
    assign REG2 = mem[2];
    assign REG3 = mem[3];
endmodule

// File: tb/tb_reg_file_cfg.sv
// Randomised self-checking bench for reg_file_cfg: one 16-entry and one
// 12-entry instance share stimulus and are compared against an array model.
module tb_reg_file_cfg;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    reg_file_cfg_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus16 ();
    reg_file_cfg_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus12 ();
    logic [7:0] r16 [4];
    logic [7:0] r12 [4];

    reg_file_cfg dut16 (
        .CLK(CLK), .RST(RST), .bus(bus16),
        .REG0(r16[0]), .REG1(r16[1]), .REG2(r16[2]), .REG3(r16[3])
    );
    reg_file_cfg #(.DEPTH(12)) dut12 (
        .CLK(CLK), .RST(RST), .bus(bus12),
        .REG0(r12[0]), .REG1(r12[1]), .REG2(r12[2]), .REG3(r12[3])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = DEPTH 16, index 1 = DEPTH 12.
    int         dep [2] = '{16, 12};
    logic [7:0] m    [2][16];
    bit         pj   [2][16];
    logic [7:0] e_rd [2];
    bit         e_v  [2];
    bit         e_e  [2];
    bit         e_p  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m[k][i]  = 8'h00;
                pj[k][i] = 1'b0;
            end
            m[k][2] = 8'h81;
            m[k][3] = 8'h20;
            e_rd[k] = 8'h00;
            e_v[k]  = 1'b0;
            e_e[k]  = 1'b0;
            e_p[k]  = 1'b0;
        end
    endtask

    task automatic check_inst(input int k, input logic [7:0] rd, input logic v, input logic e,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3);
        string n;
        n = $sformatf("d%0d", dep[k]);
        check_eq({n, "_RdData"}, 32'(rd), 32'(e_rd[k]));
        check_eq({n, "_Valid"},  32'(v),  32'(e_v[k]));
        check_eq({n, "_AddrErr"}, 32'(e), 32'(e_e[k]));
        check_eq({n, "_REG0"}, 32'(a0), 32'(m[k][0]));
        check_eq({n, "_REG1"}, 32'(a1), 32'(m[k][1]));
        check_eq({n, "_REG2"}, 32'(a2), 32'(m[k][2]));
        check_eq({n, "_REG3"}, 32'(a3), 32'(m[k][3]));
    endtask

    task automatic compare_all();
        check_inst(0, bus16.RdData, bus16.RdData_Valid, bus16.Addr_Err, r16[0], r16[1], r16[2], r16[3]);
        check_inst(1, bus12.RdData, bus12.RdData_Valid, bus12.Addr_Err, r12[0], r12[1], r12[2], r12[3]);
`ifdef REGFILE_PARITY_EN
        check_eq("d16_ParErr", 32'(bus16.Par_Err), 32'(e_p[0]));
        check_eq("d12_ParErr", 32'(bus12.Par_Err), 32'(e_p[1]));
`endif
    endtask

    task automatic drive(input logic we, input logic re, input logic [3:0] a,
                         input logic [7:0] d, input logic inj);
        bus16.WrEn = we; bus16.RdEn = re; bus16.Address = a; bus16.WrData = d;
        bus12.WrEn = we; bus12.RdEn = re; bus12.Address = a; bus12.WrData = d;
`ifdef REGFILE_PARITY_EN
        bus16.Par_Inject = inj;
        bus12.Par_Inject = inj;
`endif
    endtask

    // One access: drive, clock, apply the access rules to the model, compare.
    task automatic cycle(input logic we, input logic re, input logic [3:0] a,
                         input logic [7:0] d, input logic inj);
        bit in_range;
        drive(we, re, a, d, inj);
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            in_range = int'(a) < dep[k];
            e_v[k] = re && !we && in_range;
            e_e[k] = (we && re) || ((we || re) && !in_range);
            e_p[k] = 1'b0;
            if (we && !re && in_range) begin
                m[k][a]  = d;
                pj[k][a] = inj;
            end
            if (e_v[k]) begin
                e_rd[k] = m[k][a];
                e_p[k]  = pj[k][a];
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    initial begin
        int r;
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        model_reset();
        #1 RST = 1'b0;
        #2 compare_all();
        @(negedge CLK) RST = 1'b1;

        // Read of addr 15 on both depths; then write/read/idle hold.
        cycle(1'b0, 1'b1, 4'd15, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 4'd5, 8'hA5, 1'b0);
        cycle(1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
        idle();
        idle();

        // Config entries and reset values of 2/3.
        cycle(1'b1, 1'b0, 4'd0, 8'h3C, 1'b0);
        cycle(1'b1, 1'b0, 4'd1, 8'h0F, 1'b0);
        cycle(1'b0, 1'b1, 4'd2, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 4'd3, 8'h00, 1'b0);

        // Out of range for DEPTH 12, in range for 16.
        cycle(1'b1, 1'b0, 4'd13, 8'hFF, 1'b0);
        cycle(1'b0, 1'b1, 4'd13, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'(i), 8'h00, 1'b0);

        // Both strobes together.
        cycle(1'b1, 1'b1, 4'd4, 8'h77, 1'b0);
        cycle(1'b0, 1'b1, 4'd4, 8'h00, 1'b0);

        // Back-to-back read-after-write streams.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 4'(i + 8), 8'($urandom), 1'b0);
            cycle(1'b0, 1'b1, 4'(i + 8), 8'h00, 1'b0);
        end

`ifdef REGFILE_PARITY_EN
        cycle(1'b1, 1'b0, 4'd6, 8'h5A, 1'b1);
        cycle(1'b0, 1'b1, 4'd6, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 4'd6, 8'h5A, 1'b0);
        cycle(1'b0, 1'b1, 4'd6, 8'h00, 1'b0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            cycle(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8,
                  4'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 3) == 0);
        end

        // Reset asserted while a write strobe is pending.
        drive(1'b1, 1'b0, 4'd7, 8'h99, 1'b0);
        #2 RST = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge CLK);
        #1 compare_all();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        @(negedge CLK) RST = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'(i), 8'h00, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
